// File: rtl/alu_pkg.sv
// Shared opcode definitions for the arbitrated ALU.
// Opcode groups live in op[5:1]; op[0] picks SUB and SLL.
package alu_pkg;

  typedef logic [5:0] alu_op_t;

  localparam alu_op_t OP_ADD = 6'b000000;
  localparam alu_op_t OP_SUB = 6'b000001;
  localparam alu_op_t OP_SRL = 6'b000010;
  localparam alu_op_t OP_SLL = 6'b000011;
  localparam alu_op_t OP_SRA = 6'b000100;
  localparam alu_op_t OP_XOR = 6'b001000;
  localparam alu_op_t OP_OR  = 6'b010000;
  localparam alu_op_t OP_AND = 6'b100000;

  localparam logic [4:0] G_ADD = 5'b00000;
  localparam logic [4:0] G_SHF = 5'b00001;
  localparam logic [4:0] G_SRA = 5'b00010;
  localparam logic [4:0] G_XOR = 5'b00100;
  localparam logic [4:0] G_OR  = 5'b01000;
  localparam logic [4:0] G_AND = 5'b10000;

  function automatic logic op_legal(alu_op_t op);
    return op[5:1] inside {G_ADD, G_SHF, G_SRA, G_XOR, G_OR, G_AND};
  endfunction

endpackage

// File: rtl/alu.sv
// Combinational integer ALU shared by all requesters.
// Wraps on ADD/SUB; shift amount is the low log2(WIDTH) bits of b.
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  alu_op_t          op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  localparam int SW = $clog2(WIDTH);

  logic [SW-1:0] sh;

  assign sh = b[SW-1:0];

  always_comb begin
    y = '0;
    case (op[5:1])
      G_ADD:   y = op[0] ? a - b : a + b;
      G_SHF:   y = op[0] ? a << sh : a >> sh;
      G_SRA:   y = $unsigned($signed(a) >>> sh);
      G_XOR:   y = a ^ b;
      G_OR:    y = a | b;
      G_AND:   y = a & b;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first request at or after ptr.
// ptr moves past the winner only when the grant is taken.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] grant
);

  localparam int PW = $clog2(N);

  logic [PW-1:0] ptr;
  logic [PW-1:0] win;
  logic [PW-1:0] idx;
  logic          found;

  always_comb begin
    grant = '0;
    win   = '0;
    idx   = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      idx = PW'((int'(ptr) + i) % N);
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        win        = idx;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= (int'(win) == N - 1) ? '0 : win + 1'b1;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU among NUM_REQ requesters: S1 operands, S2 result.
// Build option ALU_ARB_ILLEGAL_OP_EN flags illegal opcodes on rsp_err_o.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NUM_REQ-1:0]       req_valid_i,
  output logic [NUM_REQ-1:0]       req_ready_o,
  input  logic [NUM_REQ*6-1:0]     req_op_i,
  input  logic [NUM_REQ*WIDTH-1:0] req_a_i,
  input  logic [NUM_REQ*WIDTH-1:0] req_b_i,
  output logic                     rsp_valid_o,
  input  logic                     rsp_ready_i,
  output logic [ID_W-1:0]          rsp_id_o,
  output logic [WIDTH-1:0]         rsp_result_o,
  output logic                     rsp_err_o
);

  logic [NUM_REQ-1:0] grant;
  logic               s1_valid;
  logic               s2_valid;
  logic               s1_free;
  logic               s2_load;
  logic               accept;
  alu_op_t            s1_op;
  alu_op_t            sel_op;
  logic [WIDTH-1:0]   s1_a;
  logic [WIDTH-1:0]   s1_b;
  logic [WIDTH-1:0]   sel_a;
  logic [WIDTH-1:0]   sel_b;
  logic [WIDTH-1:0]   alu_y;
  logic [WIDTH-1:0]   s2_next;
  logic [WIDTH-1:0]   s2_result;
  logic [ID_W-1:0]    s1_id;
  logic [ID_W-1:0]    s2_id;
  logic [ID_W-1:0]    sel_id;

  assign s2_load     = !s2_valid || rsp_ready_i;
  assign s1_free     = !s1_valid || s2_load;
  assign req_ready_o = grant & {NUM_REQ{s1_free && !rst_i}};
  assign accept      = |req_ready_o;

  rr_arbiter #(
    .N(NUM_REQ)
  ) u_arb (
    .clk    (clk_i),
    .rst    (rst_i),
    .req    (req_valid_i),
    .advance(accept),
    .grant  (grant)
  );

  always_comb begin
    sel_op = '0;
    sel_a  = '0;
    sel_b  = '0;
    sel_id = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (grant[k]) begin
        sel_op = req_op_i[k*6 +: 6];
        sel_a  = req_a_i[k*WIDTH +: WIDTH];
        sel_b  = req_b_i[k*WIDTH +: WIDTH];
        sel_id = ID_W'(k);
      end
    end
  end

  alu #(
    .WIDTH(WIDTH)
  ) u_alu (
    .op(s1_op),
    .a (s1_a),
    .b (s1_b),
    .y (alu_y)
  );

`ifdef ALU_ARB_ILLEGAL_OP_EN
  logic s1_bad;
  logic s2_err;

  assign s1_bad    = !op_legal(s1_op);
  assign s2_next   = s1_bad ? '0 : alu_y;
  assign rsp_err_o = s2_err;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s2_err <= 1'b0;
    end else if (s2_load && s1_valid) begin
      s2_err <= s1_bad;
    end
  end
`else
  assign s2_next   = alu_y;
  assign rsp_err_o = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_valid  <= 1'b0;
      s1_op     <= '0;
      s1_a      <= '0;
      s1_b      <= '0;
      s1_id     <= '0;
      s2_valid  <= 1'b0;
      s2_result <= '0;
      s2_id     <= '0;
    end else begin
      if (s1_free) begin
        s1_valid <= accept;
        if (accept) begin
          s1_op <= sel_op;
          s1_a  <= sel_a;
          s1_b  <= sel_b;
          s1_id <= sel_id;
        end
      end
      if (s2_load) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          s2_result <= s2_next;
          s2_id     <= s1_id;
        end
      end
    end
  end

  assign rsp_valid_o  = s2_valid;
  assign rsp_id_o     = s2_id;
  assign rsp_result_o = s2_result;

endmodule
